// File: rtl/spi_pixel_receiver.sv
// Receive end of the parallel-lane SPI pixel link: deserializes LINES lanes per
// chip-select frame and replays them one pixel per cycle with raster position.
module spi_pixel_receiver #(
   parameter int DATA_WIDTH       = 16,
   parameter int LINES            = 6,
   parameter int HRES             = 640,
   parameter int VRES             = 360,
   parameter int FRAME_GAP_CYCLES = 200000
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [LINES-1:0]      chip_data_in,
   input  logic                  chip_clk_in,
   input  logic                  chip_sel_in,
   output logic [DATA_WIDTH-1:0] pixel_data_out,
   output logic                  data_valid_out,
   output logic [10:0]           hcount_out,
   output logic [9:0]            vcount_out,
   output logic                  frame_start_out,
   output logic                  packet_error_out
);

   localparam int BC_W  = $clog2(DATA_WIDTH + 1);
   localparam int CNT_W = $clog2(LINES + 1);
   localparam int IC_W  = $clog2(FRAME_GAP_CYCLES + 1);

   localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(DATA_WIDTH);
   localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LINES - 1);
   localparam logic [IC_W-1:0]  IC_MAX    = IC_W'(FRAME_GAP_CYCLES);
   localparam logic [IC_W-1:0]  IC_ONE    = IC_W'(1);
   localparam logic [10:0]      H_LAST    = 11'(HRES - 1);
   localparam logic [10:0]      H_ONE     = 11'd1;
   localparam logic [9:0]       V_LAST    = 10'(VRES - 1);
   localparam logic [9:0]       V_ONE     = 10'd1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   // Synchronizers are deliberately not reset so the synced chip select is
   // already truthful on the cycle reset releases.
   logic [1:0]       clk_sync;
   logic [1:0]       sel_sync;
   logic [LINES-1:0] data_meta;
   logic [LINES-1:0] data_sync;
   logic             clk_prev;
   logic             sel_prev;

   always_ff @(posedge clk_in) begin
      clk_sync  <= {clk_sync[0], chip_clk_in};
      sel_sync  <= {sel_sync[0], chip_sel_in};
      data_meta <= chip_data_in;
      data_sync <= data_meta;
      clk_prev  <= clk_sync[1];
      sel_prev  <= sel_sync[1];
   end

   logic spi_clk_rise;
   logic cs_rise;
   logic cs_fall;

   assign spi_clk_rise = clk_sync[1] & ~clk_prev;
   assign cs_rise      = sel_sync[1] & ~sel_prev;
   assign cs_fall      = ~sel_sync[1] & sel_prev;

   logic [1:0]            rx_state;
   logic [BC_W-1:0]       bit_count;
   logic [DATA_WIDTH-1:0] shift_reg [LINES];
   logic [DATA_WIDTH-1:0] hold_reg  [LINES];
   logic                  pending;
   logic [CNT_W-1:0]      drain_left;
   logic                  draining;
   logic                  drain_start;
   logic                  busy;
   logic [IC_W-1:0]       idle_count;

   assign draining    = (drain_left != '0);
   assign drain_start = pending && !draining;
   assign busy        = pending || draining || data_valid_out;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_state         <= sel_sync[1] ? ST_IDLE : ST_DISCARD;
         bit_count        <= '0;
         pending          <= 1'b0;
         packet_error_out <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            shift_reg[i] <= '0;
            hold_reg[i]  <= '0;
         end
      end else begin
         packet_error_out <= 1'b0;
         if (drain_start) pending <= 1'b0;
         case (rx_state)
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_count <= '0;
                  for (int i = 0; i < LINES; i++) shift_reg[i] <= '0;
                  rx_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // End of frame wins over a coincident SPI clock edge.
               if (cs_rise) begin
                  if (bit_count == BC_FULL) begin
                     for (int i = 0; i < LINES; i++) hold_reg[i] <= shift_reg[i];
                     pending <= 1'b1;
                  end else begin
                     packet_error_out <= 1'b1;
                  end
                  rx_state <= ST_IDLE;
               end else if (spi_clk_rise) begin
                  if (bit_count == BC_FULL) begin
                     packet_error_out <= 1'b1;
                     rx_state         <= ST_DISCARD;
                  end else begin
                     for (int i = 0; i < LINES; i++)
                        shift_reg[i] <= {shift_reg[i][DATA_WIDTH-2:0], data_sync[i]};
                     bit_count <= bit_count + BC_ONE;
                  end
               end
            end
            ST_DISCARD: begin
               if (cs_rise) rx_state <= ST_IDLE;
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

   // The first pixel is loaded on the same edge the drain starts; drain_left
   // then counts the lanes still to be replayed.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drain_left     <= '0;
         pixel_data_out <= '0;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= 1'b0;
         if (draining) begin
            pixel_data_out <= hold_reg[drain_left - CNT_ONE];
            data_valid_out <= 1'b1;
            drain_left     <= drain_left - CNT_ONE;
         end else if (drain_start) begin
            pixel_data_out <= hold_reg[LINES-1];
            data_valid_out <= 1'b1;
            drain_left     <= CNT_START;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hcount_out <= '0;
         vcount_out <= '0;
         idle_count <= '0;
      end else begin
         if (data_valid_out) begin
            if (hcount_out == H_LAST) begin
               hcount_out <= '0;
               vcount_out <= (vcount_out == V_LAST) ? '0 : vcount_out + V_ONE;
            end else begin
               hcount_out <= hcount_out + H_ONE;
            end
         end else if (!busy && idle_count == IC_MAX) begin
            hcount_out <= '0;
            vcount_out <= '0;
         end
         if (cs_fall)
            idle_count <= '0;
         else if (sel_sync[1] && rx_state == ST_IDLE && !busy && idle_count != IC_MAX)
            idle_count <= idle_count + IC_ONE;
      end
   end

   assign frame_start_out = data_valid_out && (hcount_out == '0) && (vcount_out == '0);

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Directed bench for spi_pixel_receiver: bit-bangs SPI packets at clk/6 and
// scoreboards every emitted pixel against a raster-position model.
module tb_spi_pixel_receiver;

   localparam int DW    = 16;
   localparam int LINES = 6;
   localparam int HRES  = 640;
   localparam int VRES  = 3;
   localparam int GAP   = 400;
   localparam int EXP_W = 1 + 10 + 11 + DW;

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic [LINES-1:0] chip_data_in;
   logic             chip_clk_in;
   logic             chip_sel_in;
   logic [DW-1:0]    pixel_data_out;
   logic             data_valid_out;
   logic [10:0]      hcount_out;
   logic [9:0]       vcount_out;
   logic             frame_start_out;
   logic             packet_error_out;

   spi_pixel_receiver #(
      .DATA_WIDTH(DW), .LINES(LINES), .HRES(HRES), .VRES(VRES), .FRAME_GAP_CYCLES(GAP)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .chip_data_in(chip_data_in),
      .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in),
      .pixel_data_out(pixel_data_out), .data_valid_out(data_valid_out),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .frame_start_out(frame_start_out), .packet_error_out(packet_error_out)
   );

   always #5 clk_in = ~clk_in;

   int n_compared   = 0;
   int n_mismatched = 0;
   logic [EXP_W-1:0] exp_q[$];
   int mh = 0;
   int mv = 0;
   int err_count   = 0;
   int err_run     = 0;
   int valid_total = 0;
   int run_len     = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard / monitor: every valid pixel is matched against exp_q.
   always @(negedge clk_in) begin
      if (data_valid_out) begin
         run_len++;
         valid_total++;
         check("pixel_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0)
            check("pixel_fs_v_h_data", {frame_start_out, vcount_out, hcount_out, pixel_data_out},
                  exp_q.pop_front());
      end else if (run_len != 0) begin
         check("burst_length", run_len, LINES);
         run_len = 0;
      end
      if (packet_error_out) begin
         err_count++;
         err_run++;
      end else if (err_run != 0) begin
         check("error_pulse_width", err_run, 1);
         err_run = 0;
      end
   end

   task automatic model_advance();
      if (mh == HRES - 1) begin
         mh = 0;
         mv = (mv == VRES - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   task automatic expect_packet(input logic [LINES*DW-1:0] lanes);
      for (int k = LINES - 1; k >= 0; k--) begin
         exp_q.push_back({(mh == 0 && mv == 0), 10'(mv), 11'(mh), lanes[k*DW +: DW]});
         model_advance();
      end
   endtask

   task automatic spi_bits(input logic [LINES*DW-1:0] lanes, input int nbits);
      for (int b = 0; b < nbits; b++) begin
         for (int l = 0; l < LINES; l++)
            chip_data_in[l] = (b < DW) ? lanes[l*DW + DW - 1 - b] : 1'($urandom_range(0, 1));
         repeat (3) @(negedge clk_in);
         chip_clk_in = 1'b1;
         repeat (3) @(negedge clk_in);
         chip_clk_in = 1'b0;
      end
   endtask

   task automatic send_packet(input logic [LINES*DW-1:0] lanes, input int nbits, input int gap);
      chip_sel_in = 1'b0;
      repeat (2) @(negedge clk_in);
      spi_bits(lanes, nbits);
      repeat (3) @(negedge clk_in);
      chip_sel_in = 1'b1;
      repeat (gap) @(negedge clk_in);
   endtask

   task automatic wait_drained();
      int n = 0;
      while ((exp_q.size() != 0 || data_valid_out) && n < 60) begin
         @(negedge clk_in);
         n++;
      end
      check("drain_complete", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, data_valid_out, 0);
      check({tag, "_pixel"}, pixel_data_out, 0);
      check({tag, "_hcount"}, hcount_out, 0);
      check({tag, "_vcount"}, vcount_out, 0);
      check({tag, "_frame_start"}, frame_start_out, 0);
      check({tag, "_error"}, packet_error_out, 0);
   endtask

   task automatic check_pos(input string tag, input int h, input int v);
      check({tag, "_h"}, hcount_out, h);
      check({tag, "_v"}, vcount_out, v);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired observed=running expected=finished");
      n_mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      logic [LINES*DW-1:0] lanes;
      int lat;
      int err0;
      int vt0;

      rst_in = 1'b1;
      chip_sel_in = 1'b1;
      chip_clk_in = 1'b0;
      chip_data_in = '0;
      repeat (5) @(negedge clk_in);
      check_reset_outputs("reset");
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);

      // Single packet, lanes 5..0; latency measured from the cs pin rising.
      lanes = {16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000, 16'hA5A5};
      expect_packet(lanes);
      chip_sel_in = 1'b0;
      repeat (2) @(negedge clk_in);
      spi_bits(lanes, DW);
      repeat (3) @(negedge clk_in);
      chip_sel_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         @(negedge clk_in);
         if (data_valid_out) lat = i;
      end
      check("first_pixel_latency_3_to_4", 64'(lat >= 3 && lat <= 4), 64'd1);
      wait_drained();
      check_pos("after_single", 6, 0);

      // 107 back-to-back packets from (0,0): wrap 639->0 inside packet 107.
      rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      mh = 0;
      mv = 0;
      for (int p = 0; p < 107; p++) begin
         lanes = {$urandom, $urandom, $urandom};
         expect_packet(lanes);
         send_packet(lanes, DW, 3);
      end
      wait_drained();
      check_pos("after_107", 2, 1);

      // Short packet: one error pulse, no pixels, position untouched.
      err0 = err_count;
      vt0  = valid_total;
      send_packet({$urandom, $urandom, $urandom}, 15, 3);
      repeat (10) @(negedge clk_in);
      check("short_error_count", err_count - err0, 1);
      check("short_no_pixels", valid_total - vt0, 0);
      check_pos("after_short", 2, 1);
      lanes = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0};
      expect_packet(lanes);
      send_packet(lanes, DW, 3);
      wait_drained();
      check_pos("after_good", 8, 1);

      // Overrun: 17 clocks in one frame.
      err0 = err_count;
      vt0  = valid_total;
      send_packet({$urandom, $urandom, $urandom}, 17, 3);
      repeat (10) @(negedge clk_in);
      check("overrun_error_count", err_count - err0, 1);
      check("overrun_no_pixels", valid_total - vt0, 0);
      check_pos("after_overrun", 8, 1);

      // Reset at bit 8 with cs held low across release.
      err0 = err_count;
      vt0  = valid_total;
      chip_sel_in = 1'b0;
      repeat (2) @(negedge clk_in);
      spi_bits({$urandom, $urandom, $urandom}, 8);
      rst_in = 1'b1;
      repeat (4) @(negedge clk_in);
      check_reset_outputs("midreset");
      rst_in = 1'b0;
      spi_bits({$urandom, $urandom, $urandom}, 8);
      repeat (3) @(negedge clk_in);
      chip_sel_in = 1'b1;
      repeat (12) @(negedge clk_in);
      check("midreset_no_error", err_count - err0, 0);
      check("midreset_no_pixels", valid_total - vt0, 0);
      mh = 0;
      mv = 0;
      lanes = {16'hAAAA, 16'h5555, 16'h00FF, 16'hFF00, 16'h1111, 16'h8001};
      expect_packet(lanes);
      send_packet(lanes, DW, 3);
      wait_drained();
      check_pos("after_midreset", 6, 0);

      // Rest of the frame: 6 + 319*6 = 1920 = HRES*VRES, so both counters wrap.
      for (int p = 0; p < 319; p++) begin
         lanes = {$urandom, $urandom, $urandom};
         expect_packet(lanes);
         send_packet(lanes, DW, 3);
      end
      wait_drained();
      check_pos("frame_wrap", 0, 0);
      lanes = {$urandom, $urandom, $urandom};
      expect_packet(lanes);
      send_packet(lanes, DW, 3);
      wait_drained();
      check_pos("new_frame", 6, 0);

      // Idle shorter than the gap keeps position; a full gap resyncs to (0,0).
      repeat (300) @(negedge clk_in);
      check_pos("short_idle", 6, 0);
      repeat (GAP + 40) @(negedge clk_in);
      check_pos("gap_resync", 0, 0);
      mh = 0;
      mv = 0;
      lanes = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      expect_packet(lanes);
      send_packet(lanes, DW, 3);
      wait_drained();
      check_pos("after_resync", 6, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
